mlp_layer_serializer: RTL
=========================

// Module: mlp_layer_serializer
// PURPOSE
// Parametrised inter-layer serializer for the MLP pipeline. Captures a layer's parallel output vector
// (NUM_NEURON x DATA_WIDTH) when it is valid and streams it to the next layer as LANES neurons per beat.
// Supports valid/ready backpressure, a one-deep pending buffer for back-to-back vectors, a partial-last-beat
// keep mask and a sticky overflow flag. Replaces the fixed one-word IDLE/SEND shifters between layers.
// PARAMETERS
// DATA_WIDTH  16  bits per neuron output
// NUM_NEURON  30  neurons per input vector; must be >= 1
// LANES       1   neurons per output beat; 1 <= LANES <= NUM_NEURON
// (derived) BEATS = ceil(NUM_NEURON/LANES); REM = NUM_NEURON % LANES
// PORTS
// s_axi_aclk     in   1                      clock
// s_axi_aresetn  in   1                      reset, asynchronous, active-low
// soft_reset     in   1                      synchronous clear, same effect as reset (from register block)
// in_valid       in   1                      1-cycle pulse: in_data holds a complete vector
// in_data        in   NUM_NEURON*DATA_WIDTH  neuron n at bits [n*DATA_WIDTH +: DATA_WIDTH]
// out_data       out  LANES*DATA_WIDTH       current beat; lane j at bits [j*DATA_WIDTH +: DATA_WIDTH]
// out_valid      out  1                      beat valid
// out_ready      in   1                      downstream accepts beat when out_valid && out_ready
// out_keep       out  LANES                  lane j carries a real neuron
// out_last       out  1                      final beat of the vector
// busy           out  1                      SEND state or pending buffer occupied
// overflow       out  1                      sticky: a vector was dropped
// BEHAVIOUR
// - Reset (async assert, or soft_reset at clock edge): state IDLE, hold/pend buffers and pend_full cleared,
//   beat_cnt 0. Outputs out_valid, out_last, busy, overflow 0; out_data 0; out_keep 0.
// - States: IDLE, SEND. out_valid = (state==SEND), registered. out_keep/out_last are 0 when out_valid=0.
// - IDLE: in_valid -> hold <= in_data, beat_cnt <= 0, state SEND. The first beat is valid the next cycle
//   (latency 1 clock from in_valid to first out_valid).
// - Beat k, lane j = neuron k*LANES+j. out_data = low LANES*DATA_WIDTH bits of hold. On handshake:
//   hold >>= LANES*DATA_WIDTH (zero fill), beat_cnt++. Without handshake, out_data/keep/last held stable.
// - out_last = (beat_cnt == BEATS-1). out_keep = all ones, except last beat when REM!=0: low REM bits set,
//   padded lanes carry zero data.
// - Handshake on the last beat: if pend_full, hold <= pend, pend_full <= 0 (or refilled, below), stay SEND;
//   else if in_valid the same cycle, hold <= in_data, stay SEND; else state IDLE. No bubble between vectors.
// - in_valid in SEND (not consumed as above): if pend empty -> pend <= in_data, pend_full <= 1;
//   if pend full and pend not draining this cycle -> vector dropped, overflow <= 1.
// - Simultaneous last-beat handshake, pend_full and in_valid: pend -> hold, in_data -> pend; no overflow.
// - overflow clears only by reset/soft_reset. busy = (state==SEND) | pend_full.
// - Reset mid-SEND: out_valid drops asynchronously; partial vector discarded, no further beats.
// - Width rule: no arithmetic on data; values pass through bit-exact.
// TESTING
// T1 DW=16,NN=4,LANES=1, in_data={4,3,2,1}, ready=1: pulse at t0 -> out_valid t1..t4, data 1,2,3,4,
//    out_last only at t4, out_valid 0 at t5, busy 0 at t5.
// T2 as T1, out_ready = 1,0,1,0,...: each word held stable while ready=0; four beats over t1..t7, order intact.
// T3 NN=5,LANES=2, neurons 1..5: beats {2,1} keep 11, {4,3} keep 11, {0,5} keep 01 with last=1.
// T4 NN=4,LANES=1, vector A at t0, B at t2, ready=1: A1..A4 at t1..t4, B1..B4 at t5..t8, overflow 0.
// T5 ready=0, three vectors A,B,C pulsed: C dropped, overflow=1; then ready=1 delivers A then B intact;
//    soft_reset pulse -> overflow 0, busy 0, out_valid 0 next cycle.
// T6 s_axi_aresetn low during beat 2 of 4: out_valid 0 immediately; after release, idle until new in_valid,
//    whose vector streams from neuron 0.

Source files
------------

// File: rtl/mlp_layer_serializer.sv
// rtl/mlp_layer_serializer.sv - captures a parallel neuron vector and streams it LANES neurons per beat
module mlp_layer_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_NEURON = 30,
  parameter int LANES      = 1
) (
  input  logic                             s_axi_aclk,
  input  logic                             s_axi_aresetn,
  input  logic                             soft_reset,
  input  logic                             in_valid,
  input  logic [NUM_NEURON*DATA_WIDTH-1:0] in_data,
  output logic [LANES*DATA_WIDTH-1:0]      out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES-1:0]                 out_keep,
  output logic                             out_last,
  output logic                             busy,
  output logic                             overflow
);

  localparam int VW    = NUM_NEURON * DATA_WIDTH;
  localparam int OW    = LANES * DATA_WIDTH;
  localparam int BEATS = (NUM_NEURON + LANES - 1) / LANES;
  localparam int REM   = NUM_NEURON % LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t          r_state;
  logic [VW-1:0]   r_hold;
  logic [VW-1:0]   r_pend;
  logic            r_pend_full;
  logic [CW-1:0]   r_beat_cnt;
  logic            r_overflow;

  logic            w_send;
  logic            w_is_last;
  logic            w_hs;
  logic            w_last_hs;
  logic            w_take_new;
  logic            w_pend_drain;
  logic [VW-1:0]   w_hold_shift;

  assign w_send       = (r_state == S_SEND);
  assign w_is_last    = (r_beat_cnt == LAST_CNT);
  assign w_hs         = w_send & out_ready;
  assign w_last_hs    = w_hs & w_is_last;
  // A new vector goes straight into hold only when the last beat leaves and nothing is pending.
  assign w_take_new   = w_last_hs & ~r_pend_full & in_valid;
  assign w_pend_drain = w_last_hs & r_pend_full;
  assign w_hold_shift = r_hold >> OW;

  assign out_valid = w_send;
  assign out_data  = r_hold[OW-1:0];
  assign out_last  = w_send & w_is_last;
  assign busy      = w_send | r_pend_full;
  assign overflow  = r_overflow;

  // Lane keep mask: all lanes on every beat except a short final beat.
  always_comb begin
    out_keep = '0;
    if (w_send) begin
      for (int j = 0; j < LANES; j++) begin
        out_keep[j] = !w_is_last || (REM == 0) || (j < REM);
      end
    end
  end

  // Serializer state machine with a one-deep pending vector buffer.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_beat_cnt  <= '0;
      r_overflow  <= 1'b0;
    end else if (soft_reset) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_beat_cnt  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_hold     <= in_data;
            r_beat_cnt <= '0;
            r_state    <= S_SEND;
          end
        end
        default: begin
          if (w_hs) begin
            if (w_is_last) begin
              r_beat_cnt <= '0;
              if (r_pend_full) begin
                r_hold <= r_pend;
              end else if (in_valid) begin
                r_hold <= in_data;
              end else begin
                r_hold  <= w_hold_shift;
                r_state <= S_IDLE;
              end
            end else begin
              r_hold     <= w_hold_shift;
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
          // Vectors arriving mid-stream park in pend; a second one while pend is held is lost.
          if (in_valid && !w_take_new) begin
            if (!r_pend_full || w_pend_drain) begin
              r_pend      <= in_data;
              r_pend_full <= 1'b1;
            end else begin
              r_overflow <= 1'b1;
            end
          end else if (w_pend_drain) begin
            r_pend_full <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
